bubble_page_buffer: RTL

Double-buffered page store between the SPI flash loader and the bubble serial output stage. The loader writes 2-bit page words (odd/even bit pair) into the free bank while the other bank is shifted out to the host one word per data-out strobe. Banks swap automatically, so the next page loads while the current page plays out. The block also reports underrun and fill status to the management logic.

---
 rtl/bubble_page_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bubble_page_buffer.sv
// Two-bank page store: the loader fills one bank while the other plays out one 2-bit word per strobe.
// Word 0 is prefetched 1 cycle after page_start; each strobe presents the next word from the following cycle.
module bubble_page_buffer #(
    parameter int   PAGE_DEPTH = 1024,
    parameter int   ADDR_W     = 10,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              master_clock,
    input  logic              n_reset,
    input  logic              wr_strobe,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [1:0]        wr_data,
    input  logic              load_done,
    output logic              load_request,
    input  logic              page_start,
    input  logic              data_out_strobe,
    output logic              bubble_out_odd,
    output logic              bubble_out_even,
    output logic              shifting,
    output logic              underrun,
    input  logic              underrun_clear
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    localparam logic [ADDR_W:0] TERM = (ADDR_W+1)'(PAGE_DEPTH);

    logic [1:0]        mem [2*PAGE_DEPTH];
    logic [1:0]        rd_data_q;
    state_t            state_q;
    logic [ADDR_W:0]   rd_ptr_q;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, rd_bank_q;
    logic              odd_q, even_q;
    logic              shifting_q;
    logic              underrun_q, underrun_d;

    logic              wr_en, ld_acc, start, miss, adv, last, rd_en;
    logic [ADDR_W:0]   rd_ptr_inc;
    logic [ADDR_W:0]   rd_addr;

    assign wr_en      = wr_strobe && !full_q[wr_bank_q];
    assign ld_acc     = load_done && !full_q[wr_bank_q];
    assign start      = (state_q == ST_IDLE) && page_start && full_q[rd_bank_q];
    assign miss       = (state_q == ST_IDLE) && page_start && !full_q[rd_bank_q];
    assign adv        = (state_q == ST_SHIFT) && data_out_strobe;
    assign last       = adv && (rd_ptr_q == TERM);
    assign rd_ptr_inc = rd_ptr_q + 1'b1;
    assign rd_en      = start || (adv && !last);
    // The read after the final word wraps to address 0; the fetched value is never presented.
    assign rd_addr    = start ? {rd_bank_q, {ADDR_W{1'b0}}}
                              : {rd_bank_q, rd_ptr_inc[ADDR_W-1:0]};

    always_comb begin
        full_d = full_q;
        if (last)
            full_d[rd_bank_q] = 1'b0;
        if (ld_acc)
            full_d[wr_bank_q] = 1'b1;
    end

    always_comb begin
        underrun_d = underrun_q;
        if (miss)
            underrun_d = 1'b1;
        else if (underrun_clear)
            underrun_d = 1'b0;
    end

    always_ff @(posedge master_clock) begin
        if (wr_en)
            mem[{wr_bank_q, wr_address}] <= wr_data;
        if (rd_en)
            rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge master_clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            odd_q      <= IDLE_LEVEL;
            even_q     <= IDLE_LEVEL;
            shifting_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            underrun_q <= underrun_d;
            if (ld_acc)
                wr_bank_q <= ~wr_bank_q;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_SHIFT;
                        rd_ptr_q   <= '0;
                        shifting_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (adv) begin
                        if (last) begin
                            state_q    <= ST_IDLE;
                            odd_q      <= IDLE_LEVEL;
                            even_q     <= IDLE_LEVEL;
                            shifting_q <= 1'b0;
                            rd_bank_q  <= ~rd_bank_q;
                        end else begin
                            odd_q    <= rd_data_q[1];
                            even_q   <= rd_data_q[0];
                            rd_ptr_q <= rd_ptr_inc;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign load_request    = !full_q[wr_bank_q];
    assign bubble_out_odd  = odd_q;
    assign bubble_out_even = even_q;
    assign shifting        = shifting_q;
    assign underrun        = underrun_q;

endmodule
